alu_issue_unit: RTL and testbench
=================================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width (only 32 supported).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: InstrValid  in  1  instruction offered.
REQ-005 SHALL have port: InstrReady  out  1  unit can accept instruction.
REQ-006 SHALL have port: Instr  in  32  MIPS word; opcode [31:26], funct [5:0], imm [15:0].
REQ-007 SHALL have port: RsData  in  32  rs register value, sampled with Instr.
REQ-008 SHALL have port: RtData  in  32  rt register value, sampled with Instr.
REQ-009 SHALL have port: Operand1  out  32  to ALU Operand1, registered.
REQ-010 SHALL have port: Operand2  out  32  to ALU Operand2, registered.
REQ-011 SHALL have port: ALUControl  out  2  to ALU: AND=00, OR=01, ADD=10, SUB=11, registered.
REQ-012 SHALL have port: ALUResult  in  32  combinational ALU result.
REQ-013 SHALL have port: Zero  in  1  ALU zero flag, meaningful for SUB only.
REQ-014 SHALL have port: ResultValid  out  1  Result/BranchTaken/IllegalOp valid.
REQ-015 SHALL have port: ResultReady  in  1  consumer accepts result.
REQ-016 SHALL have port: Result  out  32  captured result.
REQ-017 SHALL have port: BranchTaken  out  1  beq condition true.
REQ-018 SHALL have port: IllegalOp  out  1  unsupported opcode/funct.

Function
REQ-019 FSM states IDLE, EXEC, DONE; InstrReady SHALL be 1 only in IDLE.
REQ-020 IDLE: on InstrValid&&InstrReady SHALL latch decode, load Operand1/Operand2/ALUControl, go EXEC; illegal op SHALL go directly to DONE.
REQ-021 EXEC: lasts exactly one cycle; SHALL register ALUResult/Zero at its closing edge, go DONE.
REQ-022 DONE: ResultValid=1; outputs SHALL stay stable until ResultReady=1, then go IDLE (no same-cycle re-accept).
REQ-023 Latency: accept edge to ResultValid=1 SHALL be 2 cycles (legal), 1 cycle (illegal).
REQ-024 Decode SHALL be: R-type (opcode 0) funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, Operand2=RtData.
REQ-025 Decode SHALL be: opcode 0x08 addi ADD sign-extended imm; 0x0C andi AND, 0x0D ori OR zero-extended imm; 0x04 beq SUB with Operand2=RtData.
REQ-026 Operand1 SHALL always be RsData.
REQ-027 BranchTaken SHALL equal captured Zero for beq, else 0.
REQ-028 Illegal op: Result=0, BranchTaken=0, IllegalOp=1; ALU outputs SHALL be unchanged.
REQ-029 All arithmetic SHALL wrap modulo 2^32; no overflow trap.
REQ-030 Operand1/Operand2/ALUControl SHALL hold last issued values outside EXEC.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE; Operand1, Operand2, Result=0; ALUControl=00; ResultValid, BranchTaken, IllegalOp=0.
REQ-032 Reset in EXEC or DONE SHALL abort the operation; no result is delivered.

Configuration
REQ-033 Macro ALU_ISSUE_SLT_EN defined: R-type funct 0x2A SHALL issue SUB and Result={31'b0, ALUResult[31] XOR ovf}, ovf=(Op1[31]!=Op2[31])&&(ALUResult[31]!=Op1[31]).
REQ-034 Macro undefined: funct 0x2A SHALL be illegal per REQ-028.

Structure
REQ-035 Shared package SHALL hold ALUControl codes, opcode/funct constants, FSM state encoding.
REQ-036 Combinational decoder SHALL be a sub-module alu_issue_decode (Instr -> ALUControl, imm-select, extend-mode, is_beq, is_slt, illegal).

Verification
REQ-037 add Rs=5, Rt=7 -> ALUControl=10, Result=12, ResultValid 2 cycles after accept.
REQ-038 beq Rs=Rt=3 -> ALUControl=11, Result=0, BranchTaken=1; Rs=3, Rt=4 -> BranchTaken=0.
REQ-039 addi imm=0xFFFF, Rs=1 -> Operand2=0xFFFFFFFF, Result=0; ori imm=0xFFFF, Rs=0 -> Result=0x0000FFFF.
REQ-040 slt Rs=0xFFFFFFFF, Rt=1 -> Result=1 with ALU_ISSUE_SLT_EN; IllegalOp=1, Result=0 after 1 cycle without it.
REQ-041 Hold ResultReady=0 for 5 cycles in DONE -> Result stable, InstrReady=0; release -> IDLE next cycle.
REQ-042 rst_n=0 during EXEC -> next cycle all outputs at reset values, InstrReady=1, no ResultValid pulse.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue unit: ALU control codes, MIPS opcode/funct
// values, FSM state encoding and the immediate-extension helper.
package alu_issue_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_t;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_t mode);
        logic [31:0] ext;
        if (mode == EXT_SIGN) ext = {{16{imm[15]}}, imm};
        else                  ext = {16'h0000, imm};
        return ext;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decoder for the ALU issue unit.
// Build option: ALU_ISSUE_SLT_EN adds R-type slt (issued as SUB).
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] Instr,
    output logic [1:0]  alu_ctrl,
    output logic        imm_sel,
    output ext_t        ext_mode,
    output logic        is_beq,
    output logic        is_slt,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = Instr[31:26];
    assign funct  = Instr[5:0];

    // Register-number and immediate fields are not needed to pick the operation.
    assign unused_fields = ^Instr[25:6];

    always_comb begin
        alu_ctrl = ALU_ADD;
        imm_sel  = 1'b0;
        ext_mode = EXT_ZERO;
        is_beq   = 1'b0;
        is_slt   = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: alu_ctrl = ALU_ADD;
                    FN_SUB: alu_ctrl = ALU_SUB;
                    FN_AND: alu_ctrl = ALU_AND;
                    FN_OR:  alu_ctrl = ALU_OR;
`ifdef ALU_ISSUE_SLT_EN
                    FN_SLT: begin
                        alu_ctrl = ALU_SUB;
                        is_slt   = 1'b1;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                alu_ctrl = ALU_ADD;
                imm_sel  = 1'b1;
                ext_mode = EXT_SIGN;
            end
            OP_ANDI: begin
                alu_ctrl = ALU_AND;
                imm_sel  = 1'b1;
            end
            OP_ORI: begin
                alu_ctrl = ALU_OR;
                imm_sel  = 1'b1;
            end
            OP_BEQ: begin
                alu_ctrl = ALU_SUB;
                is_beq   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue front end for an external combinational ALU: decodes one MIPS
// instruction, drives registered operands, captures the result. Option: ALU_ISSUE_SLT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for an instruction (only state with InstrReady=1)
// ST_EXEC | operands on the ALU for one cycle; result captured at exit
// ST_DONE | ResultValid=1, outputs frozen until ResultReady
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InstrValid,
    output logic              InstrReady,
    input  logic [31:0]       Instr,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    output logic [DATA_W-1:0] Operand1,
    output logic [DATA_W-1:0] Operand2,
    output logic [1:0]        ALUControl,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              Zero,
    output logic              ResultValid,
    input  logic              ResultReady,
    output logic [DATA_W-1:0] Result,
    output logic              BranchTaken,
    output logic              IllegalOp
);

    state_t state_q, state_d;

    logic [1:0]        dec_alu_ctrl;
    logic              dec_imm_sel;
    ext_t              dec_ext_mode;
    logic              dec_is_beq;
    logic              dec_is_slt;
    logic              dec_illegal;
    logic              accept;
    logic              beq_q;
    logic              slt_q;
    logic              ovf;
    logic [DATA_W-1:0] op2_sel;
    logic [DATA_W-1:0] slt_result;

    alu_issue_decode u_decode (
        .Instr    (Instr),
        .alu_ctrl (dec_alu_ctrl),
        .imm_sel  (dec_imm_sel),
        .ext_mode (dec_ext_mode),
        .is_beq   (dec_is_beq),
        .is_slt   (dec_is_slt),
        .illegal  (dec_illegal)
    );

    assign op2_sel = dec_imm_sel ? extend_imm(Instr[15:0], dec_ext_mode) : RtData;
    assign accept  = InstrValid && InstrReady;

    // Signed less-than from the SUB result, corrected for two's-complement overflow.
    assign ovf        = (Operand1[DATA_W-1] != Operand2[DATA_W-1]) &&
                        (ALUResult[DATA_W-1] != Operand1[DATA_W-1]);
    assign slt_result = {{(DATA_W-1){1'b0}}, ALUResult[DATA_W-1] ^ ovf};

    always_comb begin
        state_d     = state_q;
        InstrReady  = 1'b0;
        ResultValid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                InstrReady = 1'b1;
                if (InstrValid) state_d = dec_illegal ? ST_DONE : ST_EXEC;
            end
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: begin
                ResultValid = 1'b1;
                if (ResultReady) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            Operand1    <= '0;
            Operand2    <= '0;
            ALUControl  <= ALU_AND;
            Result      <= '0;
            BranchTaken <= 1'b0;
            IllegalOp   <= 1'b0;
            beq_q       <= 1'b0;
            slt_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (dec_illegal) begin
                    // ALU-facing registers keep the last issued operation.
                    Result      <= '0;
                    BranchTaken <= 1'b0;
                    IllegalOp   <= 1'b1;
                end else begin
                    Operand1   <= RsData;
                    Operand2   <= op2_sel;
                    ALUControl <= dec_alu_ctrl;
                    beq_q      <= dec_is_beq;
                    slt_q      <= dec_is_slt;
                end
            end
            if (state_q == ST_EXEC) begin
                Result      <= slt_q ? slt_result : ALUResult;
                BranchTaken <= beq_q && Zero;
                IllegalOp   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a behavioural ALU attached.
module tb_alu_issue_unit;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  ctrl;
        logic [31:0] res;
        logic        br;
        logic        ill;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [1:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        ResultValid;
    logic        ResultReady;
    logic [31:0] Result;
    logic        BranchTaken;
    logic        IllegalOp;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    logic [31:0] last_op1;
    logic [31:0] last_op2;
    logic [1:0]  last_ctrl;

    always #5 clk = ~clk;

    alu_issue_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Instr       (Instr),
        .RsData      (RsData),
        .RtData      (RtData),
        .Operand1    (Operand1),
        .Operand2    (Operand2),
        .ALUControl  (ALUControl),
        .ALUResult   (ALUResult),
        .Zero        (Zero),
        .ResultValid (ResultValid),
        .ResultReady (ResultReady),
        .Result      (Result),
        .BranchTaken (BranchTaken),
        .IllegalOp   (IllegalOp)
    );

    always_comb begin
        ALUResult = 32'h0;
        case (ALUControl)
            2'b00: ALUResult = Operand1 & Operand2;
            2'b01: ALUResult = Operand1 | Operand2;
            2'b10: ALUResult = Operand1 + Operand2;
            2'b11: ALUResult = Operand1 - Operand2;
            default: ALUResult = 32'h0;
        endcase
        Zero = (ALUResult == 32'h0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] rs,
                                   input logic [31:0] rt);
        exp_t        e;
        logic        legal;
        logic        slt;
        logic        beq;
        logic        ovf;
        logic [31:0] b;
        logic [31:0] r;
        logic [1:0]  c;
        legal = 1'b1;
        slt   = 1'b0;
        beq   = 1'b0;
        b     = rt;
        c     = 2'b10;
        r     = 32'h0;
        case (instr[31:26])
            6'h00: begin
                case (instr[5:0])
                    6'h20: c = 2'b10;
                    6'h22: c = 2'b11;
                    6'h24: c = 2'b00;
                    6'h25: c = 2'b01;
`ifdef ALU_ISSUE_SLT_EN
                    6'h2A: begin c = 2'b11; slt = 1'b1; end
`endif
                    default: legal = 1'b0;
                endcase
            end
            6'h08: begin c = 2'b10; b = {{16{instr[15]}}, instr[15:0]}; end
            6'h0C: begin c = 2'b00; b = {16'h0, instr[15:0]}; end
            6'h0D: begin c = 2'b01; b = {16'h0, instr[15:0]}; end
            6'h04: begin c = 2'b11; beq = 1'b1; end
            default: legal = 1'b0;
        endcase
        e.op1  = last_op1;
        e.op2  = last_op2;
        e.ctrl = last_ctrl;
        e.res  = 32'h0;
        e.br   = 1'b0;
        e.ill  = 1'b1;
        e.lat  = 1;
        if (legal) begin
            case (c)
                2'b00: r = rs & b;
                2'b01: r = rs | b;
                2'b10: r = rs + b;
                default: r = rs - b;
            endcase
            ovf    = (rs[31] != b[31]) && (r[31] != rs[31]);
            e.op1  = rs;
            e.op2  = b;
            e.ctrl = c;
            e.res  = slt ? {31'h0, r[31] ^ ovf} : r;
            e.br   = beq && (r == 32'h0);
            e.ill  = 1'b0;
            e.lat  = 2;
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs,
                         input logic [31:0] rt, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        check("ready_in_idle", {31'h0, InstrReady}, 32'h1);
        InstrValid = 1'b1;
        Instr      = instr;
        RsData     = rs;
        RtData     = rt;
        sb_q.push_back(model(instr, rs, rt));
        @(posedge clk);
        @(negedge clk);
        InstrValid = 1'b0;
        Instr      = $urandom;
        RsData     = $urandom;
        RtData     = $urandom;
        lat = 1;
        while (!ResultValid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'h0, 32'h1);
        end else begin
            e = sb_q.pop_front();
            check("latency", 32'(lat), 32'(e.lat));
            check("result_valid", {31'h0, ResultValid}, 32'h1);
            check("operand1", Operand1, e.op1);
            check("operand2", Operand2, e.op2);
            check("alu_control", {30'h0, ALUControl}, {30'h0, e.ctrl});
            check("result", Result, e.res);
            check("branch_taken", {31'h0, BranchTaken}, {31'h0, e.br});
            check("illegal_op", {31'h0, IllegalOp}, {31'h0, e.ill});
            check("ready_in_done", {31'h0, InstrReady}, 32'h0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", {31'h0, ResultValid}, 32'h1);
                check("hold_result", Result, e.res);
                check("hold_ready", {31'h0, InstrReady}, 32'h0);
                check("hold_operand2", Operand2, e.op2);
            end
            last_op1  = e.op1;
            last_op2  = e.op2;
            last_ctrl = e.ctrl;
        end
        ResultReady = 1'b1;
        @(negedge clk);
        ResultReady = 1'b0;
        check("release_valid", {31'h0, ResultValid}, 32'h0);
        check("release_ready", {31'h0, InstrReady}, 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_operand1"}, Operand1, 32'h0);
        check({tag, "_operand2"}, Operand2, 32'h0);
        check({tag, "_alu_control"}, {30'h0, ALUControl}, 32'h0);
        check({tag, "_result"}, Result, 32'h0);
        check({tag, "_flags"}, {29'h0, ResultValid, BranchTaken, IllegalOp}, 32'h0);
        check({tag, "_ready"}, {31'h0, InstrReady}, 32'h1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [15:0] imm;
        logic [31:0] ins;
        imm = 16'($urandom);
        case ($urandom_range(0, 8))
            0: ins = rtype(6'h20);
            1: ins = rtype(6'h22);
            2: ins = rtype(6'h24);
            3: ins = rtype(6'h25);
            4: ins = itype(6'h08, imm);
            5: ins = itype(6'h0C, imm);
            6: ins = itype(6'h0D, imm);
            7: ins = itype(6'h04, imm);
            default: ins = itype(6'h23, imm);
        endcase
        return ins;
    endfunction

    initial begin
        logic [31:0] rs;
        rst_n       = 1'b0;
        InstrValid  = 1'b0;
        ResultReady = 1'b0;
        Instr       = 32'h0;
        RsData      = 32'h0;
        RtData      = 32'h0;
        last_op1    = 32'h0;
        last_op2    = 32'h0;
        last_ctrl   = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        issue(rtype(6'h20), 32'd5, 32'd7, 0);
        issue(itype(6'h04, 16'h0010), 32'd3, 32'd3, 0);
        issue(itype(6'h04, 16'h0010), 32'd3, 32'd4, 0);
        issue(itype(6'h08, 16'hFFFF), 32'd1, 32'h1234_5678, 0);
        issue(itype(6'h0D, 16'hFFFF), 32'd0, 32'h0, 0);
        issue(rtype(6'h2A), 32'hFFFF_FFFF, 32'd1, 0);
        issue(rtype(6'h2A), 32'h7FFF_FFFF, 32'h8000_0000, 0);
        issue(itype(6'h3F, 16'h0001), 32'hAAAA_AAAA, 32'h5555_5555, 0);
        issue(rtype(6'h00), 32'h1, 32'h2, 0);
        issue(rtype(6'h22), 32'd0, 32'd1, 0);
        issue(rtype(6'h24), 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        issue(rtype(6'h25), 32'hF0F0_0000, 32'h0000_0F0F, 0);
        issue(itype(6'h0C, 16'h8001), 32'hFFFF_FFFF, 32'h0, 0);
        issue(rtype(6'h20), 32'hFFFF_FFFF, 32'd2, 5);

        // Reset while the operation is in EXEC: nothing may be delivered.
        @(negedge clk);
        InstrValid = 1'b1;
        Instr      = rtype(6'h20);
        RsData     = 32'd9;
        RtData     = 32'd9;
        @(posedge clk);
        @(negedge clk);
        InstrValid = 1'b0;
        check("exec_valid_low", {31'h0, ResultValid}, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_valid", {31'h0, ResultValid}, 32'h0);
        end
        last_op1  = 32'h0;
        last_op2  = 32'h0;
        last_ctrl = 2'b00;

        for (int i = 0; i < 16; i++) begin
            rs = $urandom;
            issue(rand_instr(), rs, ($urandom_range(0, 3) == 0) ? rs : $urandom, 0);
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
